// File: rtl/divisor_seq_pkg.sv
// Shared arithmetic definitions for the divider: FSM state encoding and default width.
package divisor_seq_pkg;
  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    FIM    = 2'd2
  } estado_t;
endpackage

// File: rtl/divisor_seq_sub.sv
// (W)-bit ripple subtractor a - b built as a + ~b + 1 through a chain of full-adder cells.
module subtrator_nb #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] dif,
  output logic         borrow
);
  logic [W:0]   c;
  logic [W-1:0] nb;

  assign nb   = ~b;
  assign c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign dif[i]  = a[i] ^ nb[i] ^ c[i];
    assign c[i+1]  = (a[i] & nb[i]) | (c[i] & (a[i] ^ nb[i]));
  end

  // No carry out of the top cell means a < b.
  assign borrow = ~c[W];
endmodule

// File: rtl/divisor_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
module divisor_seq
  import divisor_seq_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quociente,
  output logic [N-1:0] resto,
  output logic         ocupado,
  output logic         pronto,
  output logic         div_zero
);
  localparam int CW = $clog2(N + 1);

  estado_t       state, nstate;
  logic [N-1:0]  q, q_d, q_step;
  logic [N:0]    r, r_d, r_sh, r_step, dif;
  logic [N-1:0]  d, d_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [N-1:0]  quo_d, res_d;
  logic          dz_d, pronto_d, ocupado_d, borrow;

  // Shift in the next dividend bit, then trial-subtract the divisor.
  assign r_sh = {r[N-1:0], q[N-1]};

  subtrator_nb #(.W(N + 1)) u_sub (
    .a      (r_sh),
    .b      ({1'b0, d}),
    .dif    (dif),
    .borrow (borrow)
  );

  assign q_step = {q[N-2:0], ~borrow};
  assign r_step = borrow ? r_sh : dif;

  always_ff @(posedge clk) begin
    if (reset) state <= OCIOSO;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      CALC:    if (cnt == CW'(1)) nstate = FIM;
      default: begin
        if (start) nstate = (divisor == '0) ? FIM : CALC;
        else       nstate = OCIOSO;
      end
    endcase
  end

  always_comb begin
    q_d   = q;
    r_d   = r;
    d_d   = d;
    cnt_d = cnt;
    quo_d = quociente;
    res_d = resto;
    dz_d  = div_zero;
    case (state)
      CALC: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          quo_d = q_step;
          res_d = r_step[N-1:0];
          dz_d  = 1'b0;
        end
      end
      default: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d = '1;
            res_d = dividendo;
            dz_d  = 1'b1;
          end else begin
            q_d   = dividendo;
            r_d   = '0;
            d_d   = divisor;
            cnt_d = CW'(N);
          end
        end
      end
    endcase
    pronto_d  = (nstate == FIM);
    ocupado_d = (nstate == CALC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q         <= '0;
      r         <= '0;
      d         <= '0;
      cnt       <= '0;
      quociente <= '0;
      resto     <= '0;
      div_zero  <= 1'b0;
      pronto    <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      q         <= q_d;
      r         <= r_d;
      d         <= d_d;
      cnt       <= cnt_d;
      quociente <= quo_d;
      resto     <= res_d;
      div_zero  <= dz_d;
      pronto    <= pronto_d;
      ocupado   <= ocupado_d;
    end
  end
endmodule

// File: tb/tb_divisor_seq.sv
// Directed bench for divisor_seq: vector table, exhaustive N=4 sweep, and handshake corner cases.
module tb_divisor_seq;
  import divisor_seq_pkg::*;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividendo = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quociente, resto;
  logic         ocupado, pronto, div_zero;

  int tests = 0;
  int fails = 0;

  divisor_seq #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .quociente (quociente),
    .resto     (resto),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         edz;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starting in cycle t+lat0, advance until pronto or the cycle budget runs out.
  task automatic wait_done(input int lat0, output int lat, output int busy);
    lat  = lat0;
    busy = 0;
    while (!pronto && lat < 20) begin
      if (ocupado) busy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         output int lat, output int busy);
    @(negedge clk);
    start = 1'b1; dividendo = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, lat, busy);
  endtask

  initial begin
    vec_t vt[8];
    int   lat, busy, np;

    vt[0] = '{4'd13, 4'd3,  4'd4,  4'd1,  1'b0};
    vt[1] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0};
    vt[2] = '{4'd2,  4'd9,  4'd0,  4'd2,  1'b0};
    vt[3] = '{4'd7,  4'd0,  4'd15, 4'd7,  1'b1};
    vt[4] = '{4'd9,  4'd4,  4'd2,  4'd1,  1'b0};
    vt[5] = '{4'd0,  4'd5,  4'd0,  4'd0,  1'b0};
    vt[6] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0};
    vt[7] = '{4'd8,  4'd0,  4'd15, 4'd8,  1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_quo", quociente, 0);
    chk("rst_res", resto, 0);
    chk("rst_ocup", ocupado, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_dz", div_zero, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_div(vt[i].a, vt[i].b, lat, busy);
      chk($sformatf("v%0d_lat", i), lat, vt[i].edz ? 1 : 5);
      chk($sformatf("v%0d_busy", i), busy, vt[i].edz ? 0 : 4);
      chk($sformatf("v%0d_ocup_fim", i), ocupado, 0);
      chk($sformatf("v%0d_quo", i), quociente, vt[i].eq);
      chk($sformatf("v%0d_res", i), resto, vt[i].er);
      chk($sformatf("v%0d_dz", i), div_zero, vt[i].edz);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse", i), pronto, 0);
      chk($sformatf("v%0d_hold_q", i), quociente, vt[i].eq);
      chk($sformatf("v%0d_hold_r", i), resto, vt[i].er);
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(4'(a), 4'(b), lat, busy);
        if (b != 0) begin
          chk($sformatf("sw_inv_%0d_%0d", a, b), int'(quociente) * b + int'(resto), a);
          chk($sformatf("sw_rlt_%0d_%0d", a, b), int'(resto < 4'(b)), 1);
        end else begin
          chk($sformatf("sw_z_q_%0d", a), quociente, 15);
          chk($sformatf("sw_z_r_%0d", a), resto, a);
          chk($sformatf("sw_z_dz_%0d", a), div_zero, 1);
        end
      end
    end

    // start with other operands during CALC must be ignored
    @(negedge clk);
    start = 1'b1; dividendo = 4'd13; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; dividendo = 4'd2; divisor = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, lat, busy);
    chk("ign_lat", lat, 5);
    chk("ign_quo", quociente, 4);
    chk("ign_res", resto, 1);

    // start held while in FIM launches the next division back-to-back
    start = 1'b1; dividendo = 4'd10; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_ocup", ocupado, 1);
    chk("b2b_pronto_off", pronto, 0);
    wait_done(1, lat, busy);
    chk("b2b_lat", lat, 5);
    chk("b2b_quo", quociente, 3);
    chk("b2b_res", resto, 1);

    // reset in the third CALC cycle discards the division
    @(negedge clk);
    start = 1'b1; dividendo = 4'd13; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mr_quo", quociente, 0);
    chk("mr_res", resto, 0);
    chk("mr_ocup", ocupado, 0);
    chk("mr_pronto", pronto, 0);
    chk("mr_dz", div_zero, 0);
    chk("mr_state", int'(dut.state), int'(OCIOSO));
    np = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (pronto || ocupado) np++;
    end
    chk("mr_discard", np, 0);

    run_div(4'd12, 4'd5, lat, busy);
    chk("pr_lat", lat, 5);
    chk("pr_busy", busy, 4);
    chk("pr_quo", quociente, 2);
    chk("pr_res", resto, 2);
    chk("pr_dz", div_zero, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
